uart_rx: RTL and testbench

UART receive engine sitting directly downstream of the 2-flop `synchronizer` on the serial RX pin. It consumes the already-synchronized line, detects start bits, samples each bit at its centre, and checks the stop bit. Received words are presented on a valid/ready output port to the command/FIFO logic.

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: takes the synchronized serial line, centre-samples each bit, checks the stop bit.
// The word appears on a valid/ready port one cycle after the stop-bit sample; an unaccepted word blocks new ones (overrun).
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 word_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        word_done = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_i) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line half a bit in; a short low pulse is dropped silently.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_i) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_i, sh_q[DATA_BITS-1:1]};
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit lets a following start edge be caught with no idle gap.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_i) begin
                        word_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A word accepted this same cycle frees the slot for the new one.
        if (word_done) begin
            if (!valid_q || ready_i) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit, 8 data bits.
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int DB     = 8;
    localparam int HALF   = CPB / 2;
    localparam int TS_OFF = HALF + (DB + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         exp_vld;
        logic [7:0] exp_dat;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [5];

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         ferr_cnt, ovr_cnt, ferr_cyc, ovr_cyc;
    int         rise_cyc [$];
    logic [7:0] rise_dat [$];
    logic       vld_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // One clock; outputs are observed 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (valid_o && !vld_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(data_o);
        end
        vld_prev = valid_o;
        if (frame_err_o) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (overrun_o) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
    endtask

    task automatic clear_mon;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        ferr_cyc = -1;
        ovr_cyc  = -1;
        rise_cyc.delete();
        rise_dat.delete();
    endtask

    // t0 is the edge that first sees the start bit low.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        rx_i = 1'b0;
        tick;
        t0 = cyc;
        repeat (CPB - 1) tick;
        for (int k = 0; k < DB; k++) begin
            rx_i = b[k];
            repeat (CPB) tick;
        end
        rx_i = stop;
        repeat (CPB) tick;
    endtask

    function automatic int rise_at(input int i);
        return (rise_cyc.size() > i) ? rise_cyc[i] : -1;
    endfunction

    function automatic int dat_at(input int i);
        return (rise_dat.size() > i) ? int'(rise_dat[i]) : -1;
    endfunction

    initial begin
        int t0;
        int ta;
        int tb;

        vecs[0] = '{dat: 8'hA5, stop: 1'b1, exp_vld: 1, exp_dat: 8'hA5, exp_ferr: 0};
        vecs[1] = '{dat: 8'h00, stop: 1'b1, exp_vld: 1, exp_dat: 8'h00, exp_ferr: 0};
        vecs[2] = '{dat: 8'hFF, stop: 1'b1, exp_vld: 1, exp_dat: 8'hFF, exp_ferr: 0};
        vecs[3] = '{dat: 8'h3C, stop: 1'b0, exp_vld: 0, exp_dat: 8'h00, exp_ferr: 1};
        vecs[4] = '{dat: 8'h96, stop: 1'b1, exp_vld: 1, exp_dat: 8'h96, exp_ferr: 0};

        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        clear_mon();
        repeat (3) tick;
        check("reset data_o",      int'(data_o),      0);
        check("reset valid_o",     int'(valid_o),     0);
        check("reset frame_err_o", int'(frame_err_o), 0);
        check("reset overrun_o",   int'(overrun_o),   0);
        check("reset busy_o",      int'(busy_o),      0);
        rst_n = 1'b1;
        repeat (4) tick;

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            send_frame(vecs[v].dat, vecs[v].stop, t0);
            rx_i = 1'b1;
            repeat (20) tick;
            check($sformatf("vec%0d valid count", v), rise_cyc.size(), vecs[v].exp_vld);
            check($sformatf("vec%0d valid cycle", v), rise_at(0),
                  (vecs[v].exp_vld != 0) ? t0 + TS_OFF : -1);
            check($sformatf("vec%0d data", v), dat_at(0),
                  (vecs[v].exp_vld != 0) ? int'(vecs[v].exp_dat) : -1);
            check($sformatf("vec%0d frame_err count", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d frame_err cycle", v), ferr_cyc,
                  (vecs[v].exp_ferr != 0) ? t0 + TS_OFF : -1);
            check($sformatf("vec%0d overrun count", v), ovr_cnt, 0);
            check($sformatf("vec%0d busy after", v), int'(busy_o), 0);
        end

        // Glitch: 4 low cycles
        clear_mon();
        rx_i = 1'b0;
        tick;
        t0 = cyc;
        repeat (3) tick;
        rx_i = 1'b1;
        tick;
        check("glitch busy in start", int'(busy_o), 1);
        while (cyc < t0 + 9) tick;
        check("glitch busy by t0+9", int'(busy_o), 0);
        repeat (30) tick;
        check("glitch valid count", rise_cyc.size(), 0);
        check("glitch frame_err count", ferr_cnt, 0);

        // Framing error with line held low, then recovery
        clear_mon();
        send_frame(8'h3C, 1'b0, t0);
        rx_i = 1'b0;
        repeat (40) tick;
        check("break busy held", int'(busy_o), 1);
        check("break frame_err count", ferr_cnt, 1);
        check("break frame_err cycle", ferr_cyc, t0 + TS_OFF);
        check("break valid count", rise_cyc.size(), 0);
        rx_i = 1'b1;
        tick;
        check("break exit busy", int'(busy_o), 0);
        repeat (5) tick;
        clear_mon();
        send_frame(8'h81, 1'b1, t0);
        rx_i = 1'b1;
        repeat (10) tick;
        check("recovery valid cycle", rise_at(0), t0 + TS_OFF);
        check("recovery data", dat_at(0), 8'h81);

        // Overrun with consumer stalled
        ready_i = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, ta);
        rx_i = 1'b1;
        repeat (10) tick;
        send_frame(8'h22, 1'b1, tb);
        rx_i = 1'b1;
        repeat (10) tick;
        check("overrun valid count", rise_cyc.size(), 1);
        check("overrun first valid cycle", rise_at(0), ta + TS_OFF);
        check("overrun data kept", int'(data_o), 8'h11);
        check("overrun valid held", int'(valid_o), 1);
        check("overrun pulse count", ovr_cnt, 1);
        check("overrun pulse cycle", ovr_cyc, tb + TS_OFF);
        ready_i = 1'b1;
        tick;
        check("overrun valid drop", int'(valid_o), 0);

        // Back-to-back frames with no idle bits
        repeat (5) tick;
        clear_mon();
        send_frame(8'h00, 1'b1, ta);
        send_frame(8'hFF, 1'b1, tb);
        rx_i = 1'b1;
        repeat (10) tick;
        check("b2b valid count", rise_cyc.size(), 2);
        check("b2b first valid cycle", rise_at(0), ta + TS_OFF);
        check("b2b spacing", rise_at(1) - rise_at(0), 160);
        check("b2b data0", dat_at(0), 8'h00);
        check("b2b data1", dat_at(1), 8'hFF);

        // Reset during data bit 3
        rx_i = 1'b0;
        tick;
        repeat (CPB - 1) tick;
        for (int k = 0; k < 3; k++) begin
            rx_i = (k == 1) ? 1'b1 : 1'b0;
            repeat (CPB) tick;
        end
        rx_i = 1'b1;
        repeat (HALF) tick;
        check("midframe busy", int'(busy_o), 1);
        rst_n = 1'b0;
        tick;
        tick;
        check("midreset data_o",      int'(data_o),      0);
        check("midreset valid_o",     int'(valid_o),     0);
        check("midreset frame_err_o", int'(frame_err_o), 0);
        check("midreset overrun_o",   int'(overrun_o),   0);
        check("midreset busy_o",      int'(busy_o),      0);
        rst_n = 1'b1;
        repeat (5) tick;
        clear_mon();
        send_frame(8'h5A, 1'b1, t0);
        rx_i = 1'b1;
        repeat (10) tick;
        check("post-reset valid cycle", rise_at(0), t0 + TS_OFF);
        check("post-reset data", dat_at(0), 8'h5A);
        check("post-reset frame_err count", ferr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
